regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback sources: ALU (exec) and LSU (load return).
//  Sits between the execute/memory stages and the register file.
//  Arbitrates round-robin, registers the winner and drives the register file's enable/reg_write/rd/write_data inputs.
//  Optionally tracks pending destination registers for hazard detection.
// PARAMETERS
//  DATA_W   32  write data width
//  ADDR_W   5   register index width (32 regs)
//  RR_INIT  0   requester favoured first after reset (0=ALU, 1=LSU)
// PORTS
//  clk_i            in   1       clock, all state on rising edge
//  rst_i            in   1       asynchronous, active-high reset
//  stall_i          in   1       pipeline freeze; no grants while high
//  alu_valid_i      in   1       ALU write request
//  alu_ready_o      out  1       ALU request accepted this cycle
//  alu_rd_i         in   ADDR_W  ALU destination register
//  alu_data_i       in   DATA_W  ALU result
//  lsu_valid_i      in   1       LSU write request
//  lsu_ready_o      out  1       LSU request accepted this cycle
//  lsu_rd_i         in   ADDR_W  LSU destination register
//  lsu_data_i       in   DATA_W  load data
//  rf_enable_o      out  1       register file enable (registered)
//  rf_reg_write_o   out  1       register file write strobe (registered)
//  rf_rd_o          out  ADDR_W  register file destination (registered)
//  rf_write_data_o  out  DATA_W  register file write data (registered)
// BEHAVIOUR
//  - Reset: all rf_*_o = 0; last-grant pointer set so RR_INIT wins first conflict; pending_o = 0.
//  - Handshake: transfer when valid_i & ready_o. ready_o is combinational from valid/stall/pointer.
//    valid_i, rd_i and data_i must be held stable until the transfer; a requester must not drop valid_i before it.
//  - Grant: stall_i=1 -> no ready. Single valid -> granted. Both valid -> requester not granted last wins.
//  - Pointer: updates only on an actual transfer; otherwise it holds.
//  - Latency: transfer in cycle N -> rf_enable_o=1, rf_rd_o/rf_write_data_o = winner's in cycle N+1.
//    The register file commits at the edge ending cycle N+1.
//  - No transfer in a cycle -> next-cycle rf_enable_o=0, rf_reg_write_o=0; rf_rd_o/rf_write_data_o hold.
//  - x0: a request with rd=0 is accepted (ready given). Next cycle rf_enable_o=1, rf_reg_write_o=0.
//  - Same rd from both sources: served in grant order, so the later grant's data persists.
//    Ordering between sources is the issuing stage's responsibility.
//  - stall_i mid-stream: an already registered write still issues in the following cycle; only new grants are blocked.
//  - Reset asserted mid-operation: registered write discarded immediately (rf_enable_o=0 asynchronously).
// CONFIGURATION
//  Macro WB_SCOREBOARD_EN.
//  Defined -> adds ports:
//    issue_valid_i  in   1       instruction issued with destination register
//    issue_rd_i     in   ADDR_W  issued destination register
//    pending_o      out  32      bit r = write to register r outstanding
//  Defined -> scoreboard rules:
//    - issue sets the bit; transfer clears it at the same edge the write is registered.
//    - Issue and clear of the same register in one cycle -> bit stays set (issue wins).
//    - pending_o[0] is always 0; issue with rd=0 is ignored.
//  Undefined -> ports absent; no scoreboard state.
// TESTING
//  1. Reset, then ALU only: valid, rd=5, data=0xDEADBEEF -> alu_ready_o=1 same cycle.
//     Next cycle rf_enable_o=1, rf_reg_write_o=1, rf_rd_o=5, rf_write_data_o=0xDEADBEEF.
//  2. Both valid for 4 cycles, RR_INIT=0 -> grants ALU,LSU,ALU,LSU; rf_rd_o follows with 1-cycle lag.
//  3. LSU rd=0, data=0x1234 -> lsu_ready_o=1; next cycle rf_enable_o=1, rf_reg_write_o=0.
//  4. stall_i=1 with both valid -> both ready_o=0; rf_enable_o=0 from second stall cycle.
//     Release stall -> grants resume, pointer unchanged.
//  5. Assert rst_i while rf_enable_o=1 -> rf_enable_o, rf_reg_write_o drop without waiting for a clock edge.
//     Release -> first conflict goes to RR_INIT.
//  6. (WB_SCOREBOARD_EN) issue rd=7 -> pending_o[7]=1 next cycle.
//     ALU transfer rd=7 -> pending_o[7]=0.
//     Simultaneous issue rd=7 and transfer rd=7 -> pending_o[7] stays 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU writeback.
// Optional destination-register scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              rf_enable_o,
  output logic              rf_reg_write_o,
  output logic [ADDR_W-1:0] rf_rd_o,
  output logic [DATA_W-1:0] rf_write_data_o
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic [31:0]       pending_o
`endif
);

  // High when LSU was granted last, so ALU wins the next conflict.
  logic              last_lsu;
  logic              xfer_p0;
  logic [ADDR_W-1:0] win_rd_p0;
  logic [DATA_W-1:0] win_data_p0;

  // Stage p0: combinational grant and winner select
  always_comb begin
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!stall_i) begin
      alu_ready_o = alu_valid_i && (!lsu_valid_i || last_lsu);
      lsu_ready_o = lsu_valid_i && (!alu_valid_i || !last_lsu);
    end
    xfer_p0     = alu_ready_o || lsu_ready_o;
    win_rd_p0   = lsu_ready_o ? lsu_rd_i   : alu_rd_i;
    win_data_p0 = lsu_ready_o ? lsu_data_i : alu_data_i;
  end

  // Stage p1: registered register-file write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_enable_o     <= 1'b0;
      rf_reg_write_o  <= 1'b0;
      rf_rd_o         <= '0;
      rf_write_data_o <= '0;
      last_lsu        <= ~RR_INIT;
    end else begin
      rf_enable_o    <= xfer_p0;
      rf_reg_write_o <= xfer_p0 && (win_rd_p0 != '0);
      if (xfer_p0) begin
        rf_rd_o         <= win_rd_p0;
        rf_write_data_o <= win_data_p0;
        last_lsu        <= lsu_ready_o;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending_q;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_nxt;

  // Issue is applied after the clear so a same-cycle issue keeps the bit set.
  always_comb begin
    set_mask    = (issue_valid_i && (issue_rd_i != '0)) ? (32'd1 << issue_rd_i) : 32'd0;
    clr_mask    = xfer_p0 ? (32'd1 << win_rd_p0) : 32'd0;
    pending_nxt = (pending_q & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_nxt;
  end

  assign pending_o = pending_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected writes, a monitor checks them.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, stall, av, lv;
  logic [AW-1:0] ard, lrd;
  logic [DW-1:0] ad, ld;
  logic          alu_ready, lsu_ready, rf_enable, rf_reg_write;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_data;
`ifdef WB_SCOREBOARD_EN
  logic          iv;
  logic [AW-1:0] ird;
  logic [31:0]   pending;
`endif

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_INIT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .alu_valid_i(av), .alu_ready_o(alu_ready), .alu_rd_i(ard), .alu_data_i(ad),
    .lsu_valid_i(lv), .lsu_ready_o(lsu_ready), .lsu_rd_i(lrd), .lsu_data_i(ld),
    .rf_enable_o(rf_enable), .rf_reg_write_o(rf_reg_write),
    .rf_rd_o(rf_rd), .rf_write_data_o(rf_data)
`ifdef WB_SCOREBOARD_EN
    , .issue_valid_i(iv), .issue_rd_i(ird), .pending_o(pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;

  function automatic wr_t mk(input logic rw, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    wr_t w;
    w.rw = rw; w.rd = rd; w.data = data;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && rf_enable) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_rd",   32'(rf_rd),        32'(mon_e.rd));
        chk("wr_data", rf_data,           mon_e.data);
        chk("wr_rw",   32'(rf_reg_write), 32'(mon_e.rw));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic cyc(input string name,
                     input logic a_v, input logic [AW-1:0] a_rd, input logic [DW-1:0] a_d,
                     input logic l_v, input logic [AW-1:0] l_rd, input logic [DW-1:0] l_d,
                     input logic st, input logic ea, input logic el, input wr_t ew);
    av = a_v; ard = a_rd; ad = a_d;
    lv = l_v; lrd = l_rd; ld = l_d;
    stall = st;
    @(negedge clk);
    chk({name, "_alu_rdy"}, 32'(alu_ready), 32'(ea));
    chk({name, "_lsu_rdy"}, 32'(lsu_ready), 32'(el));
    if (ea || el) exp_q.push_back(ew);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string name);
    cyc(name, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, mk(1'b0, '0, '0));
  endtask

  task automatic do_reset();
    av = 1'b0; lv = 1'b0; stall = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_en",   32'(rf_enable),    32'd0);
    chk("rst_rw",   32'(rf_reg_write), 32'd0);
    chk("rst_rd",   32'(rf_rd),        32'd0);
    chk("rst_data", rf_data,           32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; av = 1'b0; lv = 1'b0;
    ard = '0; lrd = '0; ad = '0; ld = '0;
`ifdef WB_SCOREBOARD_EN
    iv = 1'b0; ird = '0;
`endif
    @(posedge clk); #1;
`ifdef WB_SCOREBOARD_EN
    chk("rst_pending", pending, 32'd0);
`endif
    do_reset();

    // ALU alone
    cyc("t1", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd5, 32'hDEADBEEF));
    idle("t1_idle");
    chk("t1_en_low", 32'(rf_enable), 32'd0);
    chk("t1_rd_hold", 32'(rf_rd), 32'd5);

    // Conflicts alternate starting with ALU after reset
    do_reset();
    cyc("t2a", 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd1, 32'h11));
    cyc("t2b", 1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd2, 32'h22));
    cyc("t2c", 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd3, 32'h33));
    cyc("t2d", 1'b1, 5'd5, 32'h55, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd4, 32'h44));
    cyc("t2e", 1'b1, 5'd5, 32'h55, 1'b0, '0, '0,       1'b0, 1'b1, 1'b0, mk(1'b1, 5'd5, 32'h55));
    idle("t2_idle");

    // x0 write: accepted, strobe suppressed
    cyc("t3", 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h1234));

    // Stall: registered write drains, no new grants, pointer kept (LSU last -> ALU next)
    cyc("t4s1", 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0, mk(1'b0, '0, '0));
    chk("t4_en_stall2", 32'(rf_enable), 32'd0);
    cyc("t4s2", 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0, mk(1'b0, '0, '0));
    cyc("t4r1", 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd6, 32'h66));
    cyc("t4r2", 1'b0, '0, '0,       1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd8, 32'h88));
    idle("t4_idle");

    // Reset mid-write drops the registered write without a clock edge
    cyc("t5", 1'b1, 5'd10, 32'hAA, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd10, 32'hAA));
    av = 1'b0;
    chk("t5_en_before", 32'(rf_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_en_async", 32'(rf_enable),    32'd0);
    chk("t5_rw_async", 32'(rf_reg_write), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("t5a", 1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd11, 32'hB1));
    cyc("t5b", 1'b0, '0, '0,        1'b1, 5'd12, 32'hC2, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd12, 32'hC2));
    idle("t5_idle");

`ifdef WB_SCOREBOARD_EN
    iv = 1'b1; ird = 5'd7;
    idle("t6_issue");
    chk("t6_set7", 32'(pending[7]), 32'd1);
    ird = 5'd0;
    idle("t6_issue0");
    chk("t6_x0", 32'(pending[0]), 32'd0);
    iv = 1'b0;
    cyc("t6_clr", 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd7, 32'h77));
    chk("t6_clr7", 32'(pending[7]), 32'd0);
    iv = 1'b1; ird = 5'd7;
    idle("t6_reissue");
    chk("t6_reset7", 32'(pending[7]), 32'd1);
    cyc("t6_both", 1'b1, 5'd7, 32'h78, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, mk(1'b1, 5'd7, 32'h78));
    iv = 1'b0;
    chk("t6_keep7", 32'(pending[7]), 32'd1);
    idle("t6_idle");
`endif

    idle("end_idle");
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
